cache_refill_ctrl: RTL and testbench

Miss-handling and write-through controller between the processor, the 4-word-block direct-mapped data cache, and main memory. On a read miss it fetches the missing 4-word block from main memory one word at a time, then presents it to the cache with a single-cycle block-write pulse. Every processor store is written through to main memory. The processor is stalled until each access is complete.

---
 rtl/cache_refill_if.sv | 33 +++
 rtl/cache_refill_ctrl.sv | 90 +++++++++
 tb/tb_cache_refill_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_refill_if.sv
// cache_refill_if: processor, cache and main-memory signals around the refill controller
interface cache_refill_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  Mem_Rd;
  logic                  Mem_Wr;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] Data_in;
  logic                  Miss;
  logic                  Stall;
  logic                  block_wr;
  logic [DATA_WIDTH-1:0] cache_in0;
  logic [DATA_WIDTH-1:0] cache_in1;
  logic [DATA_WIDTH-1:0] cache_in2;
  logic [DATA_WIDTH-1:0] cache_in3;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport master (
    input  Mem_Rd, Mem_Wr, Address, Data_in, Miss, mem_ack, mem_rdata,
    output Stall, block_wr, cache_in0, cache_in1, cache_in2, cache_in3,
           mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output Mem_Rd, Mem_Wr, Address, Data_in, Miss, mem_ack, mem_rdata,
    input  Stall, block_wr, cache_in0, cache_in1, cache_in2, cache_in3,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: read-miss block refill and store write-through between processor, cache and memory
module cache_refill_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OFFSET     = 2
) (
  input  logic            CLK,
  input  logic            rst,
  cache_refill_if.master  bus
);
  typedef enum logic [1:0] {IDLE, FILL, LOAD, WTHRU} state_t;
  state_t                       state_q, state_d;
  logic [ADDR_WIDTH-OFFSET-1:0] base_q, base_d;
  logic [OFFSET-1:0]            word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0]        waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]        buf_q [4];
  assign bus.cache_in0 = buf_q[0];
  assign bus.cache_in1 = buf_q[1];
  assign bus.cache_in2 = buf_q[2];
  assign bus.cache_in3 = buf_q[3];
  // state and refill buffer; reset discards any partially fetched block
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      word_cnt_q <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      buf_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      word_cnt_q <= word_cnt_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      if (state_q == FILL && bus.mem_ack) buf_q[word_cnt_q] <= bus.mem_rdata;
    end
  end
  // next state, memory bus drive and processor stall; a store wins over a simultaneous load
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    word_cnt_d    = word_cnt_q;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    bus.Stall     = 1'b0;
    bus.block_wr  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      IDLE: begin
        bus.Stall = bus.Mem_Wr || (bus.Mem_Rd && bus.Miss);
        if (bus.Mem_Wr) begin
          waddr_d = bus.Address;
          wdata_d = bus.Data_in;
          state_d = WTHRU;
        end else if (bus.Mem_Rd && bus.Miss) begin
          base_d     = bus.Address[ADDR_WIDTH-1:OFFSET];
          word_cnt_d = '0;
          state_d    = FILL;
        end
      end
      FILL: begin
        bus.Stall    = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = {base_q, word_cnt_q};
        if (bus.mem_ack) begin
          word_cnt_d = word_cnt_q + OFFSET'(1);
          state_d    = (word_cnt_q == '1) ? LOAD : FILL;
        end
      end
      LOAD: begin
        bus.Stall    = 1'b1;
        bus.block_wr = 1'b1;
        state_d      = IDLE;
      end
      WTHRU: begin
        bus.Stall     = !bus.mem_ack;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = waddr_q;
        bus.mem_wdata = wdata_q;
        state_d       = bus.mem_ack ? IDLE : WTHRU;
      end
    endcase
  end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: scoreboard bench with cache and main-memory models around the refill controller
module tb_cache_refill_ctrl;
  typedef struct {logic we; logic [9:0] addr; logic [31:0] data;} beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int wait_n = 0;
  int wcnt = 0;
  int cyc;
  beat_t exp_q[$];
  logic [127:0] blk_q[$];
  logic [31:0] mem [1024];
  logic c_valid [16];
  logic [3:0] c_tag [16];
  logic [31:0] c_data [16][4];
  logic prev_pend = 1'b0;
  logic prev_we;
  logic [9:0] prev_addr;
  logic [31:0] prev_wdata;
  beat_t e;
  logic [127:0] eb, got;
  logic [3:0] li;

  cache_refill_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus();
  cache_refill_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .OFFSET(2)) dut (.CLK(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  assign bus.Miss = !(c_valid[bus.Address[5:2]] && c_tag[bus.Address[5:2]] == bus.Address[9:6]);

  // memory: acks after wait_n idle cycles per beat, decided on the falling edge
  always @(negedge clk) begin
    if (rst || bus.mem_ack) wcnt = 0;
    bus.mem_ack = 1'b0;
    if (!rst && bus.mem_req) begin
      if (wcnt == wait_n) begin
        bus.mem_ack = 1'b1;
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        else bus.mem_rdata = mem[bus.mem_addr];
      end else wcnt++;
    end
  end

  // monitor: beat and block scoreboards, beat stability, cache line load
  always @(negedge clk) begin
    #1;
    if (rst) prev_pend = 1'b0;
    else begin
      if (prev_pend && bus.mem_req) begin
        tests++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {prev_we, prev_addr, prev_wdata}) begin
          fails++;
          $display("FAIL beat_stable: we/addr/wdata %b/%h/%h, required %b/%h/%h", bus.mem_we, bus.mem_addr, bus.mem_wdata, prev_we, prev_addr, prev_wdata);
        end
      end
      prev_pend = bus.mem_req && !bus.mem_ack;
      prev_we = bus.mem_we;
      prev_addr = bus.mem_addr;
      prev_wdata = bus.mem_wdata;
      if (bus.mem_req && bus.mem_ack) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat_unexpected: we/addr %b/%h, required no beat", bus.mem_we, bus.mem_addr);
        end else begin
          e = exp_q.pop_front();
          if (bus.mem_we !== e.we || bus.mem_addr !== e.addr || (e.we && bus.mem_wdata !== e.data)) begin
            fails++;
            $display("FAIL beat: we/addr/wdata %b/%h/%h, required %b/%h/%h", bus.mem_we, bus.mem_addr, bus.mem_wdata, e.we, e.addr, e.data);
          end
        end
      end
      if (bus.block_wr) begin
        tests++;
        got = {bus.cache_in3, bus.cache_in2, bus.cache_in1, bus.cache_in0};
        if (blk_q.size() == 0) begin
          fails++;
          $display("FAIL block_unexpected: block %h, required no block_wr", got);
        end else begin
          eb = blk_q.pop_front();
          if (got !== eb || bus.mem_req !== 1'b0) begin
            fails++;
            $display("FAIL block: block %h mem_req %b, required %h mem_req 0", got, bus.mem_req, eb);
          end
        end
        li = bus.Address[5:2];
        c_valid[li] = 1'b1;
        c_tag[li] = bus.Address[9:6];
        c_data[li][0] = bus.cache_in0;
        c_data[li][1] = bus.cache_in1;
        c_data[li][2] = bus.cache_in2;
        c_data[li][3] = bus.cache_in3;
      end
    end
  end

  // processor access: queue expected traffic, hold request until Stall drops, retire on the edge
  task automatic access(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d, output int n);
    logic [3:0] idx;
    logic miss;
    idx = a[5:2];
    miss = !(c_valid[idx] && c_tag[idx] == a[9:6]);
    if (wr) exp_q.push_back(beat_t'{1'b1, a, d});
    else if (rd && miss) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(beat_t'{1'b0, {a[9:2], 2'(i)}, 32'h0});
      blk_q.push_back({mem[{a[9:2], 2'd3}], mem[{a[9:2], 2'd2}], mem[{a[9:2], 2'd1}], mem[{a[9:2], 2'd0}]});
    end
    bus.Mem_Rd = rd;
    bus.Mem_Wr = wr;
    bus.Address = a;
    bus.Data_in = d;
    n = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!bus.Stall) break;
      n++;
      if (n > 200) begin
        tests++;
        fails++;
        $display("FAIL stall_timeout: still stalled after %0d cycles, required release", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (wr && !miss) c_data[idx][a[1:0]] = d;
    bus.Mem_Rd = 1'b0;
    bus.Mem_Wr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.block_wr, bus.Stall} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: req/we/addr/wdata/blk/stall %b/%b/%h/%h/%b/%b, required all 0", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.block_wr, bus.Stall);
    end
    tests++;
    if ({bus.cache_in3, bus.cache_in2, bus.cache_in1, bus.cache_in0} !== 128'h0) begin
      fails++;
      $display("FAIL reset_cache_in: %h, required 0", {bus.cache_in3, bus.cache_in2, bus.cache_in1, bus.cache_in0});
    end
    bus.Mem_Rd = 1'b1;
    bus.Address = 10'h2C6;
    #1;
    tests++;
    if (bus.Stall !== 1'b1 || bus.mem_req !== 1'b0) begin
      fails++;
      $display("FAIL idle_rd_miss_stall: stall/req %b/%b, required 1/0", bus.Stall, bus.mem_req);
    end
    bus.Mem_Rd = 1'b0;
    bus.Mem_Wr = 1'b1;
    #1;
    tests++;
    if (bus.Stall !== 1'b1) begin
      fails++;
      $display("FAIL idle_wr_stall: stall %b, required 1", bus.Stall);
    end
    bus.Mem_Wr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_read_miss();
    for (int i = 0; i < 4; i++) mem[10'h2C4 + i] = 32'hA0 + i;
    access(1'b1, 1'b0, 10'h2C6, 32'h0, cyc);
    tests++;
    if (cyc != 6) begin
      fails++;
      $display("FAIL read_miss_stall: %0d stall cycles, required 6", cyc);
    end
    tests++;
    if (c_data[1][2] !== 32'hA2) begin
      fails++;
      $display("FAIL read_miss_data_out: %h, required a2", c_data[1][2]);
    end
  endtask

  task automatic test_read_wait();
    for (int i = 0; i < 4; i++) mem[10'h2C4 + i] = 32'hB0 + i;
    c_valid[1] = 1'b0;
    wait_n = 2;
    access(1'b1, 1'b0, 10'h2C6, 32'h0, cyc);
    wait_n = 0;
    tests++;
    if (cyc != 14) begin
      fails++;
      $display("FAIL read_wait_stall: %0d stall cycles, required 14", cyc);
    end
  endtask

  task automatic test_write_miss();
    access(1'b0, 1'b1, 10'h013, 32'hDEADBEEF, cyc);
    tests++;
    if (cyc != 1 || mem[10'h013] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL write_miss: stall %0d mem %h, required 1 deadbeef", cyc, mem[10'h013]);
    end
  endtask

  task automatic test_write_hit();
    mem[10'h013] = 32'h0;
    access(1'b1, 1'b0, 10'h011, 32'h0, cyc);
    tests++;
    if (cyc != 6) begin
      fails++;
      $display("FAIL write_hit_refill: %0d stall cycles, required 6", cyc);
    end
    access(1'b0, 1'b1, 10'h013, 32'hDEADBEEF, cyc);
    tests++;
    if (cyc != 1 || mem[10'h013] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL write_hit: stall %0d mem %h, required 1 deadbeef", cyc, mem[10'h013]);
    end
  endtask

  task automatic test_hits();
    for (int i = 0; i < 10; i++) begin
      access(1'b1, 1'b0, 10'h2C4 + 10'(i % 4), 32'h0, cyc);
      tests++;
      if (cyc != 0) begin
        fails++;
        $display("FAIL hit_%0d: %0d stall cycles, required 0", i, cyc);
      end
    end
  endtask

  task automatic test_reset_fill();
    for (int i = 0; i < 4; i++) exp_q.push_back(beat_t'{1'b0, 10'h0A4 + 10'(i), 32'h0});
    bus.Mem_Rd = 1'b1;
    bus.Address = 10'h0A5;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.Mem_Rd = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (bus.mem_req !== 1'b0 || bus.block_wr !== 1'b0 || bus.Stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_fill: req/blk/stall %b/%b/%b, required 0/0/0", bus.mem_req, bus.block_wr, bus.Stall);
    end
    tests++;
    if (exp_q.size() != 2) begin
      fails++;
      $display("FAIL reset_beats_before: %0d beats outstanding, required 2", exp_q.size());
    end
    exp_q.delete();
    rst = 1'b0;
    access(1'b1, 1'b0, 10'h0A5, 32'h0, cyc);
    tests++;
    if (cyc != 6) begin
      fails++;
      $display("FAIL reset_reissue: %0d stall cycles, required 6", cyc);
    end
  endtask

  task automatic test_rd_wr();
    access(1'b1, 1'b1, 10'h3F1, 32'h5A5A0001, cyc);
    tests++;
    if (cyc != 1 || mem[10'h3F1] !== 32'h5A5A0001) begin
      fails++;
      $display("FAIL rd_wr: stall %0d mem %h, required 1 5a5a0001", cyc, mem[10'h3F1]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h10000000 + i;
    for (int i = 0; i < 16; i++) begin
      c_valid[i] = 1'b0;
      c_tag[i] = 4'h0;
      for (int j = 0; j < 4; j++) c_data[i][j] = 32'h0;
    end
    bus.Mem_Rd = 1'b0;
    bus.Mem_Wr = 1'b0;
    bus.Address = 10'h0;
    bus.Data_in = 32'h0;
    test_reset();
    test_read_miss();
    test_read_wait();
    test_write_miss();
    test_write_hit();
    test_hits();
    test_reset_fill();
    test_rd_wr();
    repeat (3) @(posedge clk);
    tests++;
    if (exp_q.size() != 0 || blk_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d beats %0d blocks outstanding, required 0 0", exp_q.size(), blk_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
